// File: rtl/trig_seq_ctrl.sv
// Multi-stage bus trigger sequencer: up to four patterns matched in order,
// with a per-stage timeout that restarts the sequence from stage 0.
module trig_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int TO_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_idx,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [1:0]       cfg_last,
    input  logic [TO_W-1:0]  stage_to,
    input  logic             arm,
    input  logic             bus_valid,
    input  logic [WIDTH-1:0] bus_data,
    output logic             trigger,
    output logic             timeout_evt,
    output logic [1:0]       state,
    output logic [1:0]       stage
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT0 = 2'd1,
        S_SEQ   = 2'd2,
        S_DONE  = 2'd3
    } st_t;

    localparam logic [TO_W-1:0] ONE = TO_W'(1);

    st_t             st;
    logic [WIDTH-1:0] pat [4];
    logic [1:0]      last_r;
    logic [TO_W-1:0] to_r;
    logic [TO_W-1:0] cnt;
    logic [1:0]      stg;
    logic            trig_r;
    logic            to_evt_r;
    logic            hit;
    logic            to_hit;

    assign hit    = bus_valid && (bus_data == pat[stg]);
    assign to_hit = (to_r != '0) && (cnt == to_r - ONE);

    // Patterns are only writable while idle so a running sequence is stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) pat[i] <= '1;
        end else if (cfg_we && st == S_IDLE) begin
            pat[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= S_IDLE;
            stg      <= 2'd0;
            cnt      <= '0;
            trig_r   <= 1'b0;
            to_evt_r <= 1'b0;
            last_r   <= 2'd0;
            to_r     <= '0;
        end else begin
            trig_r   <= 1'b0;
            to_evt_r <= 1'b0;
            if (!arm) begin
                st  <= S_IDLE;
                stg <= 2'd0;
                cnt <= '0;
            end else begin
                unique case (st)
                    S_IDLE: begin
                        st     <= S_WAIT0;
                        stg    <= 2'd0;
                        cnt    <= '0;
                        last_r <= cfg_last;
                        to_r   <= stage_to;
                    end
                    S_WAIT0: begin
                        if (hit) begin
                            cnt <= '0;
                            if (last_r == 2'd0) begin
                                st     <= S_DONE;
                                trig_r <= 1'b1;
                            end else begin
                                st  <= S_SEQ;
                                stg <= 2'd1;
                            end
                        end
                    end
                    S_SEQ: begin
                        // A match in the timeout cycle takes precedence.
                        if (hit) begin
                            cnt <= '0;
                            if (stg == last_r) begin
                                st     <= S_DONE;
                                trig_r <= 1'b1;
                            end else begin
                                stg <= stg + 2'd1;
                            end
                        end else if (to_hit) begin
                            st       <= S_WAIT0;
                            stg      <= 2'd0;
                            cnt      <= '0;
                            to_evt_r <= 1'b1;
                        end else if (cnt != '1) begin
                            cnt <= cnt + ONE;
                        end
                    end
                    S_DONE: begin
                        st <= S_DONE;
                    end
                endcase
            end
        end
    end

    assign trigger     = trig_r;
    assign timeout_evt = to_evt_r;
    assign state       = st;
    assign stage       = stg;

endmodule

// File: doc/trig_seq_ctrl.md
TRIG_SEQ_CTRL -- requirements
Module: trig_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bus word width.
REQ-002 SHALL have parameter TO_W, default 16, meaning stage timeout counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_we  input  1  pattern write strobe.
REQ-006 SHALL have port cfg_idx  input  2  pattern slot written (stage 0-3).
REQ-007 SHALL have port cfg_data  input  WIDTH  pattern value.
REQ-008 SHALL have port cfg_last  input  2  index of final stage (0 = single-stage trigger).
REQ-009 SHALL have port stage_to  input  TO_W  max cycles waiting in stages 1-3; 0 = no timeout.
REQ-010 SHALL have port arm  input  1  level; high = run sequence, low = abort/idle.
REQ-011 SHALL have port bus_valid  input  1  bus_data qualifier.
REQ-012 SHALL have port bus_data  input  WIDTH  sniffed bus word.
REQ-013 SHALL have port trigger  output  1  one-cycle pulse on full-sequence match.
REQ-014 SHALL have port timeout_evt  output  1  one-cycle pulse when a stage times out.
REQ-015 SHALL have port state  output  2  0=IDLE, 1=WAIT0, 2=SEQ, 3=DONE.
REQ-016 SHALL have port stage  output  2  index of stage currently awaited.

Function
REQ-017 SHALL hold four WIDTH-bit pattern registers; a cfg_we edge in IDLE loads cfg_data into slot cfg_idx; cfg_we in any other state is ignored.
REQ-018 SHALL sample cfg_last and stage_to into internal registers on the IDLE->WAIT0 transition; changes while running have no effect.
REQ-019 IDLE: arm high -> WAIT0 at next edge, stage=0.
REQ-020 WAIT0: bus_valid && bus_data==pattern[0] -> if cfg_last==0, DONE with trigger; else SEQ, stage=1, timeout counter cleared.
REQ-021 SEQ: bus_valid && bus_data==pattern[stage] -> if stage==cfg_last, DONE with trigger; else stage+1, counter cleared.
REQ-022 SEQ without match: counter increments each cycle, saturating at all ones; when stage_to!=0 and counter reaches stage_to-1, next edge -> WAIT0, stage=0, timeout_evt pulse.
REQ-023 Timeout and match in same cycle: match wins, no timeout_evt.
REQ-024 Non-matching valid words SHALL not reset the sequence (non-consecutive matching allowed).
REQ-025 trigger SHALL be registered: high exactly the one cycle after the edge that sampled the final matching word (latency 1).
REQ-026 DONE: holds with trigger low until arm low; no retrigger while arm stays high.
REQ-027 arm low in any state -> IDLE at next edge, stage=0, counter cleared; priority over match (no trigger, no timeout_evt).
REQ-028 bus_valid low -> word ignored; counter still advances in SEQ.

Reset
REQ-029 reset low SHALL immediately force state=IDLE, stage=0, trigger=0, timeout_evt=0, counter=0.
REQ-030 reset SHALL set all pattern registers to all ones and internal cfg_last/stage_to copies to 0.
REQ-031 reset asserted mid-sequence SHALL abort with no trigger pulse; after release, block waits in IDLE for arm.

Verification
REQ-032 Load patterns 0x11,0x22,0x33; cfg_last=2, stage_to=0; arm; drive 0x11,0x05,0x22,0x33 valid -> states WAIT0,SEQ(1),SEQ(1),SEQ(2),DONE; trigger one cycle after 0x33.
REQ-033 cfg_last=1, stage_to=4; match 0x11 then 4 non-matching cycles -> timeout_evt pulse, state WAIT0, stage 0; no trigger.
REQ-034 stage_to=4; 0x22 on the 4th waiting cycle -> trigger, no timeout_evt.
REQ-035 cfg_we with cfg_idx=0, cfg_data=0xAA while in WAIT0 -> pattern[0] unchanged; 0xAA does not advance; original pattern still matches.
REQ-036 After reset with no configuration, arm; bus_data=0x00000000 -> no advance; bus_data=0xFFFFFFFF -> stage advances / trigger if cfg_last=0.
REQ-037 Deassert arm in same cycle as final matching word -> IDLE, trigger stays 0; reset pulse mid-SEQ -> IDLE immediately, outputs 0.
